// File: rtl/lc3_interrupt_controller.sv
// LC-3 device-side interrupt controller: latches request edges, arbitrates by priority
// against the CPU level, and presents one vector at a time with an INT/ACK handshake.
module lc3_interrupt_controller #(
    parameter int unsigned          NUM_SRC      = 4,
    parameter logic [3*NUM_SRC-1:0] SRC_PRIORITY = {3'd4, 3'd4, 3'd4, 3'd4},
    parameter logic [8*NUM_SRC-1:0] SRC_VECTOR   = {8'h83, 8'h82, 8'h81, 8'h80}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic [NUM_SRC-1:0] irq_enable,
    input  logic [NUM_SRC-1:0] irq_clear,
    input  logic [2:0]         cpu_priority,
    input  logic               int_ack,
    output logic               int_req,
    output logic [7:0]         int_vector,
    output logic [2:0]         int_priority,
    output logic [NUM_SRC-1:0] pending
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACKED   = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] prev_req;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] set_mask;
    logic [NUM_SRC-1:0] clear_mask;
    logic [NUM_SRC-1:0] sel_mask;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic [2:0]         win_prio;
    logic [7:0]         win_vec;
    logic               sel_eligible;
    logic               ack_taken;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending[i] & irq_enable[i] &
                          (SRC_PRIORITY[3*i +: 3] > cpu_priority);
        end
    end

    // Strict '>' while scanning upward keeps the lowest index on priority ties.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        win_vec   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (!win_valid || (SRC_PRIORITY[3*i +: 3] > win_prio))) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
                win_prio  = SRC_PRIORITY[3*i +: 3];
                win_vec   = SRC_VECTOR[8*i +: 8];
            end
        end
    end

    always_comb begin
        sel_mask = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            sel_mask[i] = (sel_idx == IDX_W'(i));
        end
        sel_eligible = |(eligible & sel_mask);
        ack_taken    = (state == PRESENT) && int_ack;
        set_mask     = irq_req & ~prev_req;
        clear_mask   = irq_clear | (ack_taken ? sel_mask : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= '0;
            prev_req     <= '0;
            state        <= IDLE;
            int_req      <= 1'b0;
            int_vector   <= 8'h00;
            int_priority <= 3'd0;
            sel_idx      <= '0;
        end else begin
            prev_req <= irq_req;
            // Setting is applied after clearing so a simultaneous new edge survives.
            pending  <= (pending & ~clear_mask) | set_mask;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        sel_idx      <= win_idx;
                        int_vector   <= win_vec;
                        int_priority <= win_prio;
                        int_req      <= 1'b1;
                        state        <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (int_ack) begin
                        int_req <= 1'b0;
                        state   <= ACKED;
                    end else if (!sel_eligible) begin
                        int_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ACKED: begin
                    int_req <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    int_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_interrupt_controller.sv
// Scoreboard bench: a per-cycle behavioural model queues expected status and presentations,
// and an independent monitor pops and compares them against the controller outputs.
module tb_lc3_interrupt_controller;

    logic       clk;
    logic       reset;
    logic [3:0] irq_req;
    logic [3:0] irq_enable;
    logic [3:0] irq_clear;
    logic [2:0] cpu_priority;
    logic       int_ack;
    logic       int_req;
    logic [7:0] int_vector;
    logic [2:0] int_priority;
    logic [3:0] pending;

    lc3_interrupt_controller #(
        .NUM_SRC      (4),
        .SRC_PRIORITY ({3'd4, 3'd6, 3'd4, 3'd4}),
        .SRC_VECTOR   ({8'h83, 8'h82, 8'h81, 8'h80})
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_req      (irq_req),
        .irq_enable   (irq_enable),
        .irq_clear    (irq_clear),
        .cpu_priority (cpu_priority),
        .int_ack      (int_ack),
        .int_req      (int_req),
        .int_vector   (int_vector),
        .int_priority (int_priority),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       int_req;
        logic [7:0] vec;
        logic [2:0] prio;
        logic [3:0] pend;
    } status_t;

    typedef struct packed {
        logic [7:0] vec;
        logic [2:0] prio;
    } pres_t;

    status_t stat_q[$];
    pres_t   pres_q[$];

    int checks   = 0;
    int failures = 0;

    int         prio_tab[4] = '{4, 4, 6, 4};
    logic [7:0] vec_tab[4]  = '{8'h80, 8'h81, 8'h82, 8'h83};

    logic [3:0] r_req = '0, r_en = '0, r_clr = '0;
    logic [2:0] r_cpu = '0;
    logic       r_ack = 1'b0, r_rst = 1'b1;

    logic [3:0] m_pend = '0, m_prev = '0;
    bit         m_presenting = 0, m_cool = 0;
    int         m_idx = 0;
    logic [7:0] m_vec = 8'h00;
    logic [2:0] m_prio = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit elig(input int i);
        return m_pend[i] && r_en[i] && (prio_tab[i] > int'(r_cpu));
    endfunction

    task automatic model_step();
        int best;
        int ack_idx;
        best    = -1;
        ack_idx = -1;
        if (r_rst) begin
            m_pend = '0; m_prev = '0;
            m_presenting = 0; m_cool = 0; m_idx = 0;
            m_vec = 8'h00; m_prio = 3'd0;
        end else begin
            if (m_presenting) begin
                if (r_ack) begin
                    m_presenting = 0;
                    m_cool       = 1;
                    ack_idx      = m_idx;
                end else if (!elig(m_idx)) begin
                    m_presenting = 0;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (elig(i) && (best < 0 || prio_tab[i] > prio_tab[best])) best = i;
                if (best >= 0) begin
                    m_presenting = 1;
                    m_idx        = best;
                    m_vec        = vec_tab[best];
                    m_prio       = 3'(prio_tab[best]);
                    pres_q.push_back('{vec: m_vec, prio: m_prio});
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (r_req[i] && !m_prev[i]) m_pend[i] = 1'b1;
                else if (r_clr[i] || i == ack_idx) m_pend[i] = 1'b0;
            end
            m_prev = r_req;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        reset        = r_rst;
        irq_req      = r_req;
        irq_enable   = r_en;
        irq_clear    = r_clr;
        cpu_priority = r_cpu;
        int_ack      = r_ack;
        model_step();
        stat_q.push_back('{int_req: m_presenting, vec: m_vec, prio: m_prio, pend: m_pend});
        r_clr = '0;
        r_ack = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Monitor: per-cycle status plus a presentation check on every rising int_req.
    initial begin
        status_t s;
        pres_t   p;
        logic    last_req;
        last_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("int_req", int_req, s.int_req);
                chk("pending", pending, s.pend);
                chk("int_vector", int_vector, s.vec);
                chk("int_priority", int_priority, s.prio);
                if (int_req === 1'b1 && last_req !== 1'b1) begin
                    if (pres_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL presentation actual=%0h required=none", int_vector);
                    end else begin
                        p = pres_q.pop_front();
                        chk("pres_vector", int_vector, p.vec);
                        chk("pres_priority", int_priority, p.prio);
                    end
                end
                last_req = int_req;
            end
        end
    end

    initial begin
        reset = 1'b1; irq_req = '0; irq_enable = '0; irq_clear = '0;
        cpu_priority = '0; int_ack = 1'b0;

        // Single request on src0
        r_rst = 1'b1; ticks(2); r_rst = 1'b0;
        r_en = 4'b0001; ticks(3);
        r_req = 4'b0001; tick(); r_req = 4'b0000; ticks(3);
        r_ack = 1'b1; tick(); ticks(2);

        // Priority (src2 > src1), then back-to-back presentation
        r_en = 4'hF; r_req = 4'b0110; tick(); r_req = 4'b0000; ticks(3);
        r_ack = 1'b1; tick(); ticks(4);
        r_ack = 1'b1; tick(); ticks(2);

        // Equal priority tie: src0 over src3
        r_req = 4'b1001; tick(); r_req = 4'b0000; ticks(3);
        r_ack = 1'b1; tick(); ticks(4);
        r_ack = 1'b1; tick(); ticks(3);

        // Masked by CPU level, then unmasked
        r_cpu = 3'd4; r_en = 4'b0001;
        r_req = 4'b0001; tick(); r_req = 4'b0000; ticks(3);
        r_cpu = 3'd3; ticks(3);
        r_ack = 1'b1; tick(); ticks(2); r_cpu = 3'd0;

        // Withdraw by disabling, then re-present
        r_req = 4'b0001; tick(); r_req = 4'b0000; ticks(3);
        r_en = 4'b0000; ticks(2);
        r_en = 4'b0001; ticks(3);
        r_ack = 1'b1; tick(); ticks(2);

        // Set/clear collision, held-high request does not re-pend
        r_en = 4'b0010;
        r_req = 4'b0010; r_clr = 4'b0010; tick(); ticks(3);
        r_ack = 1'b1; tick(); ticks(4);
        r_req = 4'b0000; ticks(2);

        // Reset while presenting, with a concurrent ack
        r_en = 4'b0001;
        r_req = 4'b0001; tick(); r_req = 4'b0000; ticks(2);
        r_rst = 1'b1; r_ack = 1'b1; tick(); tick();
        r_rst = 1'b0; ticks(3);

        // Randomized traffic
        r_en = 4'hF;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0)  r_req[b] = ~r_req[b];
                if ($urandom_range(15) == 0) r_en[b]  = ~r_en[b];
                if ($urandom_range(31) == 0) r_clr[b] = 1'b1;
            end
            if ($urandom_range(39) == 0) r_cpu = 3'($urandom_range(7));
            r_ack = m_presenting ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
            r_rst = ($urandom_range(499) == 0);
            tick();
        end
        r_rst = 1'b0;
        ticks(2);

        @(posedge clk);
        #3;
        chk("stat_q_drained", stat_q.size(), 0);
        chk("pres_q_drained", pres_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
